// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory bus between the memory stage and a single-port 16-bit RAM
interface mem_stage_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] dmem_addr;
  logic [15:0]       dmem_wdata;
  logic              dmem_we;
  logic              dmem_re;
  logic [15:0]       dmem_rdata;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: stack pointer, 16/32-bit data memory access, MEM/WB register
module mem_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] SP_RESET = 32'h0000_07FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       PC_in,
  input  logic [15:0]       Rdst1_val_in,
  input  logic [15:0]       Rdst2_val_in,
  input  logic [15:0]       Rdst_val_in,
  input  logic [15:0]       Rsrc_val_in,
  input  logic [2:0]        Rdst1_in,
  input  logic [2:0]        Rdst2_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              mem_type_in,
  input  logic              memToReg_in,
  input  logic              reglow_write_in,
  input  logic              reghigh_write_in,
  input  logic [1:0]        SP_src_in,
  input  logic              mem_addr_src_in,
  input  logic              mem_data_src_in,
  input  logic              PC_push_pop_in,
  input  logic              flags_push_pop_in,
  mem_stage_if.master       dmem,
  output logic              stall_out,
  output logic [ADDR_W-1:0] SP_out,
  output logic [2:0]        POP_flags_val_out,
  output logic              is_POP_flags_out,
  output logic [31:0]       ret_addr_out,
  output logic              do_ret_out,
  output logic [15:0]       Rdst1_val_out,
  output logic [15:0]       Rdst2_val_out,
  output logic [2:0]        Rdst1_out,
  output logic [2:0]        Rdst2_out,
  output logic              reglow_write_out,
  output logic              reghigh_write_out
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state;
  logic [ADDR_W-1:0] sp;
  logic [15:0]       word0_q;

  logic              wr;
  logic              rd;
  logic              access;
  logic              is32;
  logic              push;
  logic              pop;
  logic              in_second;
  logic              stack_down;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] sp_step;
  logic [31:0]       popped;
  logic [15:0]       load_word;

  always_comb begin
    wr         = mem_write_in;
    rd         = mem_read_in & ~mem_write_in;
    access     = wr | rd;
    is32       = access & mem_type_in;
    push       = (SP_src_in == 2'd1);
    pop        = (SP_src_in == 2'd2);
    in_second  = (state == SECOND);
    stack_down = mem_addr_src_in & push;
    sp_step    = is32 ? ADDR_W'(2) : ADDR_W'(1);

    // Pops read above the current SP because SP points at the next free slot.
    if (mem_addr_src_in)
      base_addr = pop ? sp + ADDR_W'(1) : sp;
    else
      base_addr = {{(ADDR_W-16){1'b0}}, Rsrc_val_in};

    if (is32 && in_second)
      addr = stack_down ? base_addr - ADDR_W'(1) : base_addr + ADDR_W'(1);
    else
      addr = base_addr;

    popped    = {dmem.dmem_rdata, word0_q};
    load_word = in_second ? word0_q : dmem.dmem_rdata;
  end

  assign dmem.dmem_addr  = addr;
  assign dmem.dmem_wdata = mem_data_src_in ? ((is32 && !in_second) ? PC_in[31:16] : PC_in[15:0])
                                           : Rdst_val_in;
  assign dmem.dmem_we    = ~reset & wr;
  assign dmem.dmem_re    = ~reset & rd;

  assign stall_out         = ~reset & is32 & ~in_second;
  assign do_ret_out        = ~reset & in_second & rd & PC_push_pop_in;
  assign is_POP_flags_out  = do_ret_out & flags_push_pop_in;
  assign POP_flags_val_out = popped[31:29];
  assign ret_addr_out      = {3'b000, popped[28:0]};
  assign SP_out            = sp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      sp                <= SP_RESET;
      word0_q           <= 16'h0000;
      Rdst1_val_out     <= 16'h0000;
      Rdst2_val_out     <= 16'h0000;
      Rdst1_out         <= 3'b000;
      Rdst2_out         <= 3'b000;
      reglow_write_out  <= 1'b0;
      reghigh_write_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is32) begin
            state   <= SECOND;
            word0_q <= dmem.dmem_rdata;
          end
        end
        SECOND:  state <= IDLE;
        default: state <= IDLE;
      endcase

      // SP moves only once the whole access (one or two words) is done.
      if (access && (in_second || !is32)) begin
        if (push)
          sp <= sp - sp_step;
        else if (pop)
          sp <= sp + sp_step;
      end

      Rdst1_val_out     <= memToReg_in ? load_word : Rdst1_val_in;
      Rdst2_val_out     <= Rdst2_val_in;
      Rdst1_out         <= Rdst1_in;
      Rdst2_out         <= Rdst2_in;
      reglow_write_out  <= reglow_write_in & ~stall_out;
      reghigh_write_out <= reghigh_write_in & ~stall_out;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_in;
  logic [15:0] Rdst1_val_in, Rdst2_val_in, Rdst_val_in, Rsrc_val_in;
  logic [2:0]  Rdst1_in, Rdst2_in;
  logic        mem_read_in, mem_write_in, mem_type_in, memToReg_in;
  logic        reglow_write_in, reghigh_write_in;
  logic [1:0]  SP_src_in;
  logic        mem_addr_src_in, mem_data_src_in, PC_push_pop_in, flags_push_pop_in;
  logic        stall_out;
  logic [31:0] SP_out;
  logic [2:0]  POP_flags_val_out;
  logic        is_POP_flags_out;
  logic [31:0] ret_addr_out;
  logic        do_ret_out;
  logic [15:0] Rdst1_val_out, Rdst2_val_out;
  logic [2:0]  Rdst1_out, Rdst2_out;
  logic        reglow_write_out, reghigh_write_out;

  logic [15:0] mem [0:4095];
  int          tests = 0;
  int          failed = 0;

  mem_stage_if #(.ADDR_W(32)) dbus ();

  always #5 clk = ~clk;

  assign dbus.dmem_rdata = mem[dbus.dmem_addr[11:0]];
  always @(posedge clk) if (dbus.dmem_we) mem[dbus.dmem_addr[11:0]] <= dbus.dmem_wdata;

  mem_stage dut (
    .clk(clk), .reset(reset), .PC_in(PC_in),
    .Rdst1_val_in(Rdst1_val_in), .Rdst2_val_in(Rdst2_val_in),
    .Rdst_val_in(Rdst_val_in), .Rsrc_val_in(Rsrc_val_in),
    .Rdst1_in(Rdst1_in), .Rdst2_in(Rdst2_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_type_in(mem_type_in), .memToReg_in(memToReg_in),
    .reglow_write_in(reglow_write_in), .reghigh_write_in(reghigh_write_in),
    .SP_src_in(SP_src_in), .mem_addr_src_in(mem_addr_src_in),
    .mem_data_src_in(mem_data_src_in), .PC_push_pop_in(PC_push_pop_in),
    .flags_push_pop_in(flags_push_pop_in), .dmem(dbus.master),
    .stall_out(stall_out), .SP_out(SP_out),
    .POP_flags_val_out(POP_flags_val_out), .is_POP_flags_out(is_POP_flags_out),
    .ret_addr_out(ret_addr_out), .do_ret_out(do_ret_out),
    .Rdst1_val_out(Rdst1_val_out), .Rdst2_val_out(Rdst2_val_out),
    .Rdst1_out(Rdst1_out), .Rdst2_out(Rdst2_out),
    .reglow_write_out(reglow_write_out), .reghigh_write_out(reghigh_write_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PC_in = 32'h0; Rdst1_val_in = 16'h0; Rdst2_val_in = 16'h0;
    Rdst_val_in = 16'h0; Rsrc_val_in = 16'h0; Rdst1_in = 3'd0; Rdst2_in = 3'd0;
    mem_read_in = 1'b0; mem_write_in = 1'b0; mem_type_in = 1'b0; memToReg_in = 1'b0;
    reglow_write_in = 1'b0; reghigh_write_in = 1'b0; SP_src_in = 2'd0;
    mem_addr_src_in = 1'b0; mem_data_src_in = 1'b0;
    PC_push_pop_in = 1'b0; flags_push_pop_in = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    idle_inputs();
    reset = 1'b1;
    mem_write_in = 1'b1;
    #3;
    // reset cycle: no strobes even with a request present
    chk("reset_we", {31'b0, dbus.dmem_we}, 32'h0);
    chk("reset_re", {31'b0, dbus.dmem_re}, 32'h0);
    tick();
    chk("reset_sp", SP_out, 32'h7FF);
    chk("reset_wb_val", {16'b0, Rdst1_val_out}, 32'h0);
    chk("reset_wb_en", {31'b0, reglow_write_out}, 32'h0);
    reset = 1'b0;
    idle_inputs();
    #3;
    chk("reset_stall", {31'b0, stall_out}, 32'h0);
    tick();

    // 16-bit push of 0xBEEF
    mem_write_in = 1'b1; SP_src_in = 2'd1; mem_addr_src_in = 1'b1; Rdst_val_in = 16'hBEEF;
    #3;
    chk("push16_addr", dbus.dmem_addr, 32'h7FF);
    chk("push16_wdata", {16'b0, dbus.dmem_wdata}, 32'hBEEF);
    chk("push16_we", {31'b0, dbus.dmem_we}, 32'h1);
    tick();
    chk("push16_sp", SP_out, 32'h7FE);
    chk("push16_mem", {16'b0, mem[12'h7FF]}, 32'hBEEF);

    // 16-bit pop into R3
    idle_inputs();
    mem_read_in = 1'b1; SP_src_in = 2'd2; mem_addr_src_in = 1'b1;
    memToReg_in = 1'b1; reglow_write_in = 1'b1; Rdst1_in = 3'd3;
    #3;
    chk("pop16_addr", dbus.dmem_addr, 32'h7FF);
    chk("pop16_re", {31'b0, dbus.dmem_re}, 32'h1);
    tick();
    chk("pop16_wb", {16'b0, Rdst1_val_out}, 32'hBEEF);
    chk("pop16_wben", {31'b0, reglow_write_out}, 32'h1);
    chk("pop16_idx", {29'b0, Rdst1_out}, 32'h3);
    chk("pop16_sp", SP_out, 32'h7FF);

    // 32-bit PC push
    idle_inputs();
    mem_write_in = 1'b1; mem_type_in = 1'b1; SP_src_in = 2'd1; mem_addr_src_in = 1'b1;
    mem_data_src_in = 1'b1; PC_in = 32'hA000_0123; reglow_write_in = 1'b1;
    #3;
    chk("push32_stall0", {31'b0, stall_out}, 32'h1);
    chk("push32_addr0", dbus.dmem_addr, 32'h7FF);
    chk("push32_wdata0", {16'b0, dbus.dmem_wdata}, 32'hA000);
    tick();
    chk("push32_bubble", {31'b0, reglow_write_out}, 32'h0);
    chk("push32_sp_mid", SP_out, 32'h7FF);
    #3;
    chk("push32_stall1", {31'b0, stall_out}, 32'h0);
    chk("push32_addr1", dbus.dmem_addr, 32'h7FE);
    chk("push32_wdata1", {16'b0, dbus.dmem_wdata}, 32'h0123);
    tick();
    chk("push32_sp", SP_out, 32'h7FD);

    // RTI pop of that frame
    idle_inputs();
    mem_read_in = 1'b1; mem_type_in = 1'b1; SP_src_in = 2'd2; mem_addr_src_in = 1'b1;
    PC_push_pop_in = 1'b1; flags_push_pop_in = 1'b1;
    #3;
    chk("rti_stall", {31'b0, stall_out}, 32'h1);
    chk("rti_addr0", dbus.dmem_addr, 32'h7FE);
    chk("rti_noret0", {31'b0, do_ret_out}, 32'h0);
    tick();
    #3;
    chk("rti_addr1", dbus.dmem_addr, 32'h7FF);
    chk("rti_do_ret", {31'b0, do_ret_out}, 32'h1);
    chk("rti_ret_addr", ret_addr_out, 32'h0000_0123);
    chk("rti_is_flags", {31'b0, is_POP_flags_out}, 32'h1);
    chk("rti_flags", {29'b0, POP_flags_val_out}, 32'h5);
    tick();
    idle_inputs();
    #3;
    chk("rti_sp", SP_out, 32'h7FF);
    chk("rti_ret_done", {31'b0, do_ret_out}, 32'h0);
    tick();

    // 32-bit load from Rsrc address: low at A, high at A+1, two-cycle WB latency
    mem_read_in = 1'b1; mem_type_in = 1'b1; Rsrc_val_in = 16'h07FE;
    memToReg_in = 1'b1; reglow_write_in = 1'b1; Rdst1_in = 3'd5;
    #3;
    chk("ld32_addr0", dbus.dmem_addr, 32'h7FE);
    tick();
    #3;
    chk("ld32_addr1", dbus.dmem_addr, 32'h7FF);
    tick();
    chk("ld32_wb", {16'b0, Rdst1_val_out}, 32'h0123);
    chk("ld32_wben", {31'b0, reglow_write_out}, 32'h1);
    chk("ld32_sp", SP_out, 32'h7FF);

    // walk SP down to 0, then push across the wrap
    idle_inputs();
    mem_write_in = 1'b1; SP_src_in = 2'd1; mem_addr_src_in = 1'b1;
    for (int i = 0; i < 2047; i++) tick();
    chk("walk_sp", SP_out, 32'h0);
    Rdst_val_in = 16'h1234;
    #3;
    chk("wrap_addr", dbus.dmem_addr, 32'h0);
    tick();
    chk("wrap_sp", SP_out, 32'hFFFF_FFFF);
    idle_inputs();
    mem_read_in = 1'b1; SP_src_in = 2'd2; mem_addr_src_in = 1'b1; memToReg_in = 1'b1;
    #3;
    chk("unwrap_addr", dbus.dmem_addr, 32'h0);
    tick();
    chk("unwrap_sp", SP_out, 32'h0);
    chk("unwrap_wb", {16'b0, Rdst1_val_out}, 32'h1234);

    // read and write together: write wins
    idle_inputs();
    mem_read_in = 1'b1; mem_write_in = 1'b1; Rsrc_val_in = 16'h0010; Rdst_val_in = 16'h5555;
    #3;
    chk("rw_we", {31'b0, dbus.dmem_we}, 32'h1);
    chk("rw_re", {31'b0, dbus.dmem_re}, 32'h0);
    tick();
    chk("rw_mem", {16'b0, mem[12'h010]}, 32'h5555);

    // reset during SECOND of a 32-bit push
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_write_in = 1'b1; mem_type_in = 1'b1; SP_src_in = 2'd1; mem_addr_src_in = 1'b1;
    mem_data_src_in = 1'b1; PC_in = 32'h1111_2222;
    tick();
    reset = 1'b1;
    #3;
    chk("rst2_we", {31'b0, dbus.dmem_we}, 32'h0);
    chk("rst2_ret", {31'b0, do_ret_out}, 32'h0);
    tick();
    reset = 1'b0;
    #3;
    chk("rst2_sp", SP_out, 32'h7FF);
    chk("rst2_idle", {31'b0, stall_out}, 32'h1);
    chk("rst2_mem_hi", {16'b0, mem[12'h7FF]}, 32'h1111);
    chk("rst2_mem_lo", {16'b0, mem[12'h7FE]}, 32'h0);
    idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

endmodule
